// File: rtl/symbol_sync_nco_if.sv
// Sample/control stream into the symbol-timing NCO and the aligned strobe/interval stream out of it.
interface symbol_sync_nco_if #(
    parameter int SAMP_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int DEC_WIDTH  = 14
);
    logic                         sample_valid;
    logic signed [SAMP_WIDTH-1:0] sample_i;
    logic signed [SAMP_WIDTH-1:0] sample_q;
    logic                         lf_valid;
    logic signed [DATA_WIDTH-1:0] lf_data;
    logic                         out_valid;
    logic signed [SAMP_WIDTH-1:0] out_i;
    logic signed [SAMP_WIDTH-1:0] out_q;
    logic                         mk;
    logic [DEC_WIDTH-1:0]         mu;
    logic                         w_clamped;

    modport master (
        output sample_valid, sample_i, sample_q, lf_valid, lf_data,
        input  out_valid, out_i, out_q, mk, mu, w_clamped
    );

    modport slave (
        input  sample_valid, sample_i, sample_q, lf_valid, lf_data,
        output out_valid, out_i, out_q, mk, mu, w_clamped
    );
endinterface

// File: rtl/symbol_sync_nco.sv
// Modulo-1 decrementing NCO: emits symbol strobe mk and fractional interval mu for the
// interpolator, stepping once per valid input sample by the clamped control word w.
module symbol_sync_nco #(
    parameter int SYM_WIDTH  = 1,
    parameter int INT_WIDTH  = 1,
    parameter int DEC_WIDTH  = 14,
    parameter int SAMP_WIDTH = 12,
    parameter logic [DEC_WIDTH-1:0] W0       = 'h2000,
    parameter logic [DEC_WIDTH-1:0] W_MIN    = 'h1800,
    parameter logic [DEC_WIDTH-1:0] W_MAX    = 'h2800,
    parameter logic [DEC_WIDTH-1:0] ETA_INIT = 'h2000
) (
    input  logic            clk,
    input  logic            rst,
    symbol_sync_nco_if.slave bus
);
    localparam int DATA_WIDTH = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int EXT        = DATA_WIDTH + 1 - DEC_WIDTH;

    logic [DEC_WIDTH-1:0] w;
    logic [DEC_WIDTH-1:0] eta;

    // Control word: W0 + lf_data, one bit wider than the filter word so it cannot wrap.
    logic signed [DATA_WIDTH:0] w_sum;
    logic                       too_low;
    logic                       too_high;
    logic [DEC_WIDTH-1:0]       w_next;

    always_comb begin
        w_sum    = $signed({{EXT{1'b0}}, W0}) + $signed({bus.lf_data[DATA_WIDTH-1], bus.lf_data});
        too_low  = w_sum < $signed({{EXT{1'b0}}, W_MIN});
        too_high = w_sum > $signed({{EXT{1'b0}}, W_MAX});
        w_next   = w_sum[DEC_WIDTH-1:0];
        if (too_low)
            w_next = W_MIN;
        else if (too_high)
            w_next = W_MAX;
    end

    // NCO step; the modulo-1 wrap is simply the low DEC_WIDTH bits of the difference.
    logic signed [DEC_WIDTH+1:0] diff;
    logic                        underflow;
    logic [DEC_WIDTH:0]          two_eta;
    logic [DEC_WIDTH-1:0]        mu_next;

    always_comb begin
        diff      = $signed({2'b00, eta}) - $signed({2'b00, w});
        underflow = diff[DEC_WIDTH+1];
        two_eta   = {eta, 1'b0};
        mu_next   = two_eta[DEC_WIDTH] ? '1 : two_eta[DEC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w             <= W0;
            eta           <= ETA_INIT;
            bus.w_clamped <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.mk        <= 1'b0;
            bus.mu        <= '0;
            bus.out_i     <= '0;
            bus.out_q     <= '0;
        end else begin
            bus.out_valid <= bus.sample_valid;
            bus.mk        <= bus.sample_valid & underflow;
            if (bus.lf_valid) begin
                w <= w_next;
                if (too_low || too_high)
                    bus.w_clamped <= 1'b1;
            end
            if (bus.sample_valid) begin
                eta       <= diff[DEC_WIDTH-1:0];
                bus.out_i <= bus.sample_i;
                bus.out_q <= bus.sample_q;
                if (underflow)
                    bus.mu <= mu_next;
            end
        end
    end
endmodule

// File: tb/tb_symbol_sync_nco.sv
// Scoreboard bench for symbol_sync_nco: integer reference model predicts each output sample.
module tb_symbol_sync_nco;
    localparam int SW   = 12;
    localparam int DW   = 16;
    localparam int FW   = 14;
    localparam int ONE  = 1 << FW;
    localparam int W0   = 'h2000;
    localparam int WMIN = 'h1800;
    localparam int WMAX = 'h2800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    symbol_sync_nco_if #(.SAMP_WIDTH(SW), .DATA_WIDTH(DW), .DEC_WIDTH(FW)) bus ();

    symbol_sync_nco dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int i;
        int q;
        int mk;
        int mu;
        int clamp;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    // reference model state: phase as an integer count of 2^-FW units
    int m_eta, m_w, m_mu, m_clamp;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic model_reset();
        m_eta = 'h2000; m_w = W0; m_mu = 0; m_clamp = 0;
    endtask

    // one clock: drive inputs, advance the model, wait for the edge
    task automatic step(input bit r, input bit sv, input bit lfv, input int lfd);
        exp_t e;
        int   s, iv, qv;
        iv = $urandom_range(0, (1 << SW) - 1);
        qv = $urandom_range(0, (1 << SW) - 1);
        rst = r;
        bus.sample_valid = sv;
        bus.sample_i = iv[SW-1:0];
        bus.sample_q = qv[SW-1:0];
        bus.lf_valid = lfv;
        bus.lf_data = lfd[DW-1:0];
        if (r) begin
            model_reset();
        end else begin
            e.mk = 0;
            if (sv) begin
                if (m_eta >= m_w) begin
                    m_eta = m_eta - m_w;
                end else begin
                    e.mk = 1;
                    m_mu = (2 * m_eta > ONE - 1) ? ONE - 1 : 2 * m_eta;
                    m_eta = m_eta - m_w + ONE;
                end
            end
            if (lfv) begin
                s = W0 + lfd;
                if (s < WMIN) begin m_w = WMIN; m_clamp = 1; end
                else if (s > WMAX) begin m_w = WMAX; m_clamp = 1; end
                else m_w = s;
            end
            if (sv) begin
                e.i = iv; e.q = qv; e.mu = m_mu; e.clamp = m_clamp;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_mk", int'(bus.mk), 0);
        chk("rst_mu", int'(bus.mu), 0);
        chk("rst_out_i", int'(unsigned'(bus.out_i)), 0);
        chk("rst_out_q", int'(unsigned'(bus.out_q)), 0);
        chk("rst_w_clamped", int'(bus.w_clamped), 0);
    endtask

    // monitor: pops one expectation per presented output sample
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_i", int'(unsigned'(bus.out_i)), e.i);
                chk("out_q", int'(unsigned'(bus.out_q)), e.q);
                chk("mk", int'(bus.mk), e.mk);
                chk("mu", int'(bus.mu), e.mu);
                chk("w_clamped", int'(bus.w_clamped), e.clamp);
            end
        end else if (!rst) begin
            chk("mk_on_gap", int'(bus.mk), 0);
        end
    end

    initial begin
        int lfd;
        model_reset();
        bus.sample_valid = 1'b0;
        bus.sample_i = '0;
        bus.sample_q = '0;
        bus.lf_valid = 1'b0;
        bus.lf_data = '0;
        @(posedge clk); #1;

        // reset held with samples offered: all discarded
        repeat (3) step(1, 1, 0, 0);
        check_reset_outputs();

        // nominal rate
        repeat (12) step(0, 1, 0, 0);

        // slow word: w = 0x199A, then mk with mu = 0x0CCC
        step(1, 0, 0, 0);
        step(0, 0, 1, -'h0666);
        repeat (6) step(0, 1, 0, 0);

        // clamp high, sticky, then clamp low
        step(0, 1, 1, 'h1000);
        step(0, 1, 1, 0);
        repeat (5) step(0, 1, 0, 0);
        step(0, 1, 1, -'h1000);
        repeat (6) step(0, 1, 0, 0);

        // gaps and lf/sample collisions
        step(1, 0, 0, 0);
        for (int k = 0; k < 24; k++) begin
            lfd = $urandom_range(0, 'h0C00) - 'h0600;
            step(0, k[0], (k % 6) == 2, lfd);
        end

        // mid-run reset, then restart as nominal
        step(1, 1, 0, 0);
        check_reset_outputs();
        repeat (10) step(0, 1, 0, 0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            do lfd = $urandom_range(0, 'h2800) - 'h1400;
            while (lfd == WMIN - W0 || lfd == WMAX - W0);
            step(k % 137 == 100, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, lfd);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
